pipe_reg_file: RTL and testbench

PIPE_REG_FILE -- requirements
Module: pipe_reg_file

---
 rtl/pipe_reg_file.sv | 112 +++++++++++
 tb/tb_pipe_reg_file.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_file.sv
// Register file with per-register pending (scoreboard) bits and a PC alias at NREG-1.
// Optional macro PIPE_REG_FILE_BYPASS_EN forwards the writeback data to a matching read port.
module pipe_reg_file #(
    parameter int WIDTH = 32,
    parameter int NREG  = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [WIDTH-1:0] r15,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             flush,
    output logic             busy1,
    output logic             busy2,
    output logic [AW:0]      pend_cnt
);

    localparam int NARCH = NREG - 1;
    localparam logic [AW:0] PC_IDX = (AW+1)'(NREG - 1);

    logic [WIDTH-1:0] regs_q [NARCH];
    logic [NARCH-1:0] pend_q;
    logic [NARCH-1:0] pend_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             wr_ok;

    assign wr_ok = we && ({1'b0, wa} < PC_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NARCH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wa] <= wd;
        end
    end

    // Issue is OR'ed in after the writeback clear so a same-cycle issue keeps the bit set.
    generate
        for (genvar gi = 0; gi < NARCH; gi++) begin : g_pend
            logic iss_hit;
            logic wb_hit;
            assign iss_hit     = iss_valid && (iss_rd == AW'(gi));
            assign wb_hit      = we && (wa == AW'(gi));
            assign pend_d[gi]  = flush ? 1'b0 : (iss_hit | (pend_q[gi] & ~wb_hit));
        end
    endgenerate

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NARCH; i++) begin
            cnt_d = cnt_d + (AW+1)'(pend_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt = cnt_q;

    always_comb begin
        rd1   = '0;
        busy1 = 1'b0;
        if ({1'b0, ra1} == PC_IDX) begin
            rd1 = r15;
        end else if ({1'b0, ra1} < PC_IDX) begin
            rd1   = regs_q[ra1];
            busy1 = pend_q[ra1];
`ifdef PIPE_REG_FILE_BYPASS_EN
            if (we && (wa == ra1)) begin
                rd1   = wd;
                busy1 = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        rd2   = '0;
        busy2 = 1'b0;
        if ({1'b0, ra2} == PC_IDX) begin
            rd2 = r15;
        end else if ({1'b0, ra2} < PC_IDX) begin
            rd2   = regs_q[ra2];
            busy2 = pend_q[ra2];
`ifdef PIPE_REG_FILE_BYPASS_EN
            if (we && (wa == ra2)) begin
                rd2   = wd;
                busy2 = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pipe_reg_file.sv
// Randomized and directed bench for pipe_reg_file against an array/bit-list reference model.
module tb_pipe_reg_file;
    localparam int WIDTH = 32;
    localparam int NREG  = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             reset, we, iss_valid, flush;
    logic [AW-1:0]    wa, ra1, ra2, iss_rd;
    logic [WIDTH-1:0] wd, r15, rd1, rd2;
    logic             busy1, busy2;
    logic [AW:0]      pend_cnt;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] m_regs [NREG-1];
    bit               m_pend [NREG-1];

    pipe_reg_file #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .r15(r15), .rd1(rd1), .rd2(rd2),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .busy1(busy1), .busy2(busy2), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_rd(input logic [AW-1:0] ra);
        if (int'(ra) == NREG-1) return r15;
        if (int'(ra) >= NREG) return '0;
`ifdef PIPE_REG_FILE_BYPASS_EN
        if (we && wa == ra) return wd;
`endif
        return m_regs[ra];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] ra);
        if (int'(ra) >= NREG-1) return 1'b0;
`ifdef PIPE_REG_FILE_BYPASS_EN
        if (we && wa == ra) return 1'b0;
`endif
        return m_pend[ra];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NREG-1; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic idle();
        reset = 0; we = 0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        r15 = 32'h108; iss_valid = 0; iss_rd = '0; flush = 0;
    endtask

    // Compare outputs before the edge, advance one clock, then apply the rules to the model.
    task automatic cycle(input string tag, input bit chk);
        #1;
        if (chk) begin
            check({tag, "/rd1"}, rd1, exp_rd(ra1));
            check({tag, "/rd2"}, rd2, exp_rd(ra2));
            check({tag, "/busy1"}, WIDTH'(busy1), WIDTH'(exp_busy(ra1)));
            check({tag, "/busy2"}, WIDTH'(busy2), WIDTH'(exp_busy(ra2)));
            check({tag, "/pend_cnt"}, WIDTH'(pend_cnt), WIDTH'(m_count()));
        end
        $display("%s rst=%0b we=%0b wa=%0d wd=%h iss=%0b rd=%0d fl=%0b ra1=%0d rd1=%h b1=%0b ra2=%0d rd2=%h b2=%0b cnt=%0d",
                 tag, reset, we, wa, wd, iss_valid, iss_rd, flush, ra1, rd1, busy1, ra2, rd2, busy2, pend_cnt);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NREG-1; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 0;
            end
        end else begin
            if (we && int'(wa) < NREG-1) m_regs[wa] = wd;
            if (flush) begin
                for (int i = 0; i < NREG-1; i++) m_pend[i] = 0;
            end else begin
                if (we && int'(wa) < NREG-1) m_pend[wa] = 0;
                if (iss_valid && int'(iss_rd) < NREG-1) m_pend[iss_rd] = 1;
            end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < NREG-1; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 0;
        end
        idle();
        reset = 1;
        cycle("init_reset", 0);

        // Alias and post-reset state
        idle(); ra1 = 4'd15; ra2 = 4'd3;
        #1;
        check("alias_rd1", rd1, 32'h108);
        check("reset_rd2", rd2, 32'h0);
        check("reset_busy2", WIDTH'(busy2), 32'h0);
        check("reset_cnt", WIDTH'(pend_cnt), 32'h0);
        cycle("alias", 1);

        // Write r2, read same cycle and next
        idle(); we = 1; wa = 4'd2; wd = 32'hDEADBEEF; ra1 = 4'd2;
        #1;
`ifdef PIPE_REG_FILE_BYPASS_EN
        check("wr_same_cycle", rd1, 32'hDEADBEEF);
`else
        check("wr_same_cycle", rd1, 32'h0);
`endif
        cycle("wr_r2", 1);
        idle(); ra1 = 4'd2;
        #1; check("wr_next_cycle", rd1, 32'hDEADBEEF);
        cycle("rd_r2", 1);

        // Issue r5, then write it back
        idle(); iss_valid = 1; iss_rd = 4'd5;
        cycle("iss_r5", 1);
        idle(); ra1 = 4'd5;
        #1;
        check("busy_r5", WIDTH'(busy1), 32'h1);
        check("cnt_r5", WIDTH'(pend_cnt), 32'h1);
        cycle("chk_r5", 1);
        idle(); we = 1; wa = 4'd5; wd = 32'h12345678;
        cycle("wb_r5", 1);
        idle(); ra1 = 4'd5;
        #1;
        check("wb_busy_r5", WIDTH'(busy1), 32'h0);
        check("wb_cnt_r5", WIDTH'(pend_cnt), 32'h0);
        cycle("post_r5", 1);

        // Issue and writeback to r7 together: issue wins
        idle(); iss_valid = 1; iss_rd = 4'd7; we = 1; wa = 4'd7; wd = 32'hA5A5_0007;
        cycle("iss_wb_r7", 1);
        idle(); ra1 = 4'd7;
        #1;
        check("r7_busy", WIDTH'(busy1), 32'h1);
        check("r7_data", rd1, 32'hA5A5_0007);
        cycle("chk_r7", 1);
        idle(); we = 1; wa = 4'd7; wd = 32'h7;
        cycle("clr_r7", 1);

        // Three issues, then flush with a discarded issue
        for (int r = 1; r <= 3; r++) begin
            idle(); iss_valid = 1; iss_rd = AW'(r);
            cycle("iss_multi", 1);
        end
        idle();
        #1; check("cnt_three", WIDTH'(pend_cnt), 32'h3);
        idle(); flush = 1; iss_valid = 1; iss_rd = 4'd4;
        cycle("flush", 1);
        idle(); ra1 = 4'd4; ra2 = 4'd1;
        #1;
        check("flush_cnt", WIDTH'(pend_cnt), 32'h0);
        check("flush_busy_r4", WIDTH'(busy1), 32'h0);
        check("flush_busy_r1", WIDTH'(busy2), 32'h0);
        cycle("post_flush", 1);

        // Reset overrides a same-cycle write and clears pending
        idle(); iss_valid = 1; iss_rd = 4'd6;
        cycle("iss_r6", 1);
        idle(); reset = 1; we = 1; wa = 4'd6; wd = 32'h55;
        cycle("rst_wr_r6", 1);
        idle(); ra1 = 4'd6; ra2 = 4'd2;
        #1;
        check("rst_r6", rd1, 32'h0);
        check("rst_busy_r6", WIDTH'(busy1), 32'h0);
        check("rst_r2", rd2, 32'h0);
        check("rst_cnt", WIDTH'(pend_cnt), 32'h0);
        cycle("post_rst", 1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            we        = $urandom_range(0, 2) == 0;
            wa        = AW'($urandom_range(0, 15));
            wd        = $urandom;
            iss_valid = $urandom_range(0, 1) == 1;
            iss_rd    = AW'($urandom_range(0, 15));
            flush     = ($urandom_range(0, 15) == 0);
            ra1       = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
            ra2       = ($urandom_range(0, 3) == 0) ? iss_rd : AW'($urandom_range(0, 15));
            r15       = $urandom;
            cycle("rand", 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
